// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// instruction-fetch port and the data port of the core. Each cycle a winner is
// picked combinationally. The data port has priority. The instruction port is
// forced through after STARVE_MAX consecutive data grants while it is waiting.
// Read data comes back to the owning port one cycle after its grant, with a
// single-cycle valid pulse. Each port's last returned word is held until its
// next valid pulse.
//
// Handshake (both ports): a requester raises *_req and holds its address, mask
// and data stable until it sees *_gnt=1 in the same cycle. A cycle with req=1
// and gnt=1 is one accepted access. If req drops before gnt, the request is
// simply gone. Reads return *_rvalid=1 exactly one cycle after the grant.
// Writes never produce an rvalid.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   i_req/i_addr       instruction read request and address
//   i_gnt              instruction access issued this cycle
//   i_rvalid/i_rdata   instruction read return (data held between returns)
//   d_req/d_wen/d_addr/d_wdata  data request; d_wen==0 is a read
//   d_gnt              data access issued this cycle
//   d_rvalid/d_rdata   data read return (data held between returns)
//   ram_en/ram_wen/ram_addr/ram_wdata  SRAM command pins
//   ram_rdata          SRAM read data, valid the cycle after a read enable
//   o_dbg_state        current FSM state (last-cycle issue), for observation
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_wen,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,

    output logic [1:0]          o_dbg_state
);

    localparam int WEN_W = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // State records which kind of access was issued in the previous cycle.
    // That tells us who owns the ram_rdata arriving in the current cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IRD  = 2'd1,
        S_DRD  = 2'd2,
        S_DWR  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [CNT_W-1:0]   w_starve_nxt;
    logic [DATA_W-1:0]  r_i_hold;
    logic [DATA_W-1:0]  r_d_hold;

    logic               w_starved;
    logic               w_d_win;
    logic               w_i_win;
    logic               w_d_is_write;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    // The instruction port only overrides data once it has watched
    // STARVE_MAX data grants go by while it was requesting.
    assign w_starved    = i_req && (r_starve_cnt == CNT_MAX);
    assign w_d_win      = d_req && !w_starved;
    assign w_i_win      = i_req && !w_d_win;
    assign w_d_is_write = (d_wen != '0);

    // Grants and the SRAM command are gated by resetn. This keeps the bus
    // quiet for the whole reset window, not only after the first edge.
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        ram_en    = 1'b0;
        ram_wen   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (resetn) begin
            if (w_d_win) begin
                d_gnt     = 1'b1;
                ram_en    = 1'b1;
                ram_wen   = d_wen;
                ram_addr  = d_addr;
                ram_wdata = d_wdata;
            end else if (w_i_win) begin
                i_gnt     = 1'b1;
                ram_en    = 1'b1;
                ram_addr  = i_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Anti-starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_req || w_i_win) begin
            w_starve_nxt = '0;
        end else if (w_d_win && (r_starve_cnt != CNT_MAX)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Issue-tracking FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every state can move to any other state, so accesses run back to back
    // without bubbles.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_d_win) begin
            w_state_nxt = w_d_is_write ? S_DWR : S_DRD;
        end else if (w_i_win) begin
            w_state_nxt = S_IRD;
        end
    end

    // ------------------------------------------------------------------
    // Read return and hold registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_i_hold <= '0;
            r_d_hold <= '0;
        end else begin
            if (r_state == S_IRD) r_i_hold <= ram_rdata;
            if (r_state == S_DRD) r_d_hold <= ram_rdata;
        end
    end

    // On the return cycle the live SRAM data goes straight through. Between
    // returns the port sees its held copy.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = r_i_hold;
        d_rdata  = r_d_hold;
        unique case (r_state)
            S_IRD: begin
                i_rvalid = 1'b1;
                i_rdata  = ram_rdata;
            end
            S_DRD: begin
                d_rvalid = 1'b1;
                d_rdata  = ram_rdata;
            end
            default: ;
        endcase
    end

    assign o_dbg_state = r_state;

    // Mask width sanity: the byte-enable bus must cover the data word exactly.
    logic [WEN_W-1:0] w_unused_wen_chk;
    assign w_unused_wen_chk = ram_wen;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0;
  logic [3:0]        d_wen = '0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .o_dbg_state(dbg_state)
  );

  // ---------------- SRAM model: word at byte address a starts as {C0DE, a[15:0]} ----
  logic [31:0] mem [0:4095];
  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = {16'hC0DE, 16'(k * 4)};
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) mem[ram_addr[13:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[13:2]];
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wen = '0; d_addr = '0; d_wdata = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200;
    @(negedge clk);
    n_tests++;
    if ({i_gnt, d_gnt, ram_en, ram_wen, i_rvalid, d_rvalid} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt/en/wen/rvalid=%b required 0", {i_gnt, d_gnt, ram_en, ram_wen, i_rvalid, d_rvalid});
    end
    n_tests++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: i=%h d=%h required 0", i_rdata, d_rdata);
    end
    n_tests++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    @(posedge clk); #1;
    idle_inputs();
    resetn = 1'b1;
    next_cycle();
  endtask

  // Three back-to-back instruction reads at 0x100.
  task automatic test_inst_stream();
    for (int c = 0; c < 4; c++) begin
      i_req = (c < 3); i_addr = 32'h100;
      @(negedge clk);
      n_tests++;
      if (i_gnt !== (c < 3) || d_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL inst_gnt c%0d: i_gnt=%b d_gnt=%b required %b 0", c, i_gnt, d_gnt, (c < 3));
      end
      if (c < 3) begin
        n_tests++;
        if (ram_addr !== 32'h100 || ram_en !== 1'b1 || ram_wen !== 4'b0) begin
          n_fail++;
          $display("FAIL inst_ram c%0d: addr=%h en=%b wen=%b required 100 1 0", c, ram_addr, ram_en, ram_wen);
        end
      end
      n_tests++;
      if (i_rvalid !== (c >= 1)) begin
        n_fail++;
        $display("FAIL inst_rvalid c%0d: got %b required %b", c, i_rvalid, (c >= 1));
      end
      if (c >= 1) begin
        n_tests++;
        if (i_rdata !== 32'hC0DE0100) begin
          n_fail++;
          $display("FAIL inst_rdata c%0d: got %h required C0DE0100", c, i_rdata);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Simultaneous requests: data first, instruction next cycle.
  task automatic test_priority();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h2000; d_wen = 4'b0;
    @(negedge clk);
    n_tests++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || ram_addr !== 32'h2000) begin
      n_fail++;
      $display("FAIL prio_c0: d_gnt=%b i_gnt=%b addr=%h required 1 0 2000", d_gnt, i_gnt, ram_addr);
    end
    next_cycle();
    // Data port parked with junk mask/data while not requesting.
    d_req = 1'b0; d_wen = 4'b1111; d_wdata = 32'h12345678;
    @(negedge clk);
    n_tests++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || ram_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL prio_c1_gnt: i_gnt=%b d_gnt=%b addr=%h required 1 0 300", i_gnt, d_gnt, ram_addr);
    end
    n_tests++;
    if (ram_wen !== 4'b0 || ram_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL prio_inst_wr_zero: wen=%b wdata=%h required 0 0", ram_wen, ram_wdata);
    end
    n_tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE2000) begin
      n_fail++;
      $display("FAIL prio_c1_drd: d_rvalid=%b d_rdata=%h required 1 C0DE2000", d_rvalid, d_rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hC0DE0300 || d_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_c2: i_rvalid=%b i_rdata=%h d_rvalid=%b required 1 C0DE0300 0", i_rvalid, i_rdata, d_rvalid);
    end
    n_tests++;
    if (ram_en !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL prio_idle_bus: en=%b addr=%h wdata=%h required 0 0 0", ram_en, ram_addr, ram_wdata);
    end
    next_cycle();
  endtask

  // Both ports saturated: D,D,D,D,I repeating.
  task automatic test_starvation();
    logic exp_i;
    logic exp_iv;
    logic exp_dv;
    for (int c = 0; c < 21; c++) begin
      i_req = (c < 20); i_addr = 32'h100;
      d_req = (c < 20); d_addr = 32'h2000; d_wen = 4'b0;
      exp_i  = (c < 20) && (c % 5 == 4);
      exp_iv = (c > 0) && ((c - 1) % 5 == 4);
      exp_dv = (c > 0) && ((c - 1) % 5 != 4);
      @(negedge clk);
      if (c < 20) begin
        n_tests++;
        if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
          n_fail++;
          $display("FAIL starve_gnt c%0d: i_gnt=%b d_gnt=%b required %b %b", c, i_gnt, d_gnt, exp_i, !exp_i);
        end
      end
      n_tests++;
      if (i_rvalid !== exp_iv || d_rvalid !== exp_dv) begin
        n_fail++;
        $display("FAIL starve_rvalid c%0d: i_rvalid=%b d_rvalid=%b required %b %b", c, i_rvalid, d_rvalid, exp_iv, exp_dv);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  // Partial write then read back.
  task automatic test_write();
    d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++;
    if (d_gnt !== 1'b1 || ram_en !== 1'b1 || ram_wen !== 4'b0011 ||
        ram_wdata !== 32'hDEADBEEF || ram_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL wr_cmd: gnt=%b en=%b wen=%b wdata=%h addr=%h required 1 1 0011 DEADBEEF 40",
               d_gnt, ram_en, ram_wen, ram_wdata, ram_addr);
    end
    next_cycle();
    d_wen = 4'b0; d_wdata = '0;
    @(negedge clk);
    n_tests++;
    if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL wr_no_rvalid: d_rvalid=%b d_gnt=%b state=%0d required 0 1 3", d_rvalid, d_gnt, dbg_state);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DEBEEF) begin
      n_fail++;
      $display("FAIL wr_readback: d_rvalid=%b d_rdata=%h required 1 C0DEBEEF", d_rvalid, d_rdata);
    end
    n_tests++;
    if (ram_en !== 1'b0 || ram_wen !== 4'b0) begin
      n_fail++;
      $display("FAIL wr_idle_bus: en=%b wen=%b required 0 0", ram_en, ram_wen);
    end
    next_cycle();
  endtask

  // Reset with an instruction read in flight.
  task automatic test_reset_inflight();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    n_tests++;
    if (i_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_gnt: i_gnt=%b required 1", i_gnt);
    end
    next_cycle();
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (i_rvalid !== 1'b0 || i_gnt !== 1'b0 || ram_en !== 1'b0 || i_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_inflight c%0d: rvalid=%b gnt=%b en=%b rdata=%h required 0 0 0 0",
                 c, i_rvalid, i_gnt, ram_en, i_rdata);
      end
      next_cycle();
    end
    resetn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (i_gnt !== 1'b1 || i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_resume: gnt=%b rvalid=%b rdata=%h required 1 0 0", i_gnt, i_rvalid, i_rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hC0DE0100) begin
      n_fail++;
      $display("FAIL rst_resume_rd: rvalid=%b rdata=%h required 1 C0DE0100", i_rvalid, i_rdata);
    end
    next_cycle();
  endtask

  // Data read 0x10 then instruction read 0x20, back to back.
  task automatic test_back_to_back();
    d_req = 1'b1; d_addr = 32'h10; d_wen = 4'b0;
    @(negedge clk);
    n_tests++;
    if (d_gnt !== 1'b1 || ram_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL b2b_c0: d_gnt=%b addr=%h required 1 10", d_gnt, ram_addr);
    end
    next_cycle();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h20;
    @(negedge clk);
    n_tests++;
    if (i_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE0010 || i_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_c1: i_gnt=%b d_rvalid=%b d_rdata=%h i_rvalid=%b required 1 1 C0DE0010 0",
               i_gnt, d_rvalid, d_rdata, i_rvalid);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hC0DE0020 || d_rvalid !== 1'b0 || d_rdata !== 32'hC0DE0010) begin
      n_fail++;
      $display("FAIL b2b_c2: i_rvalid=%b i_rdata=%h d_rvalid=%b d_rdata=%h required 1 C0DE0020 0 C0DE0010",
               i_rvalid, i_rdata, d_rvalid, d_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (i_rvalid !== 1'b0 || i_rdata !== 32'hC0DE0020 || d_rdata !== 32'hC0DE0010) begin
      n_fail++;
      $display("FAIL b2b_hold: i_rvalid=%b i_rdata=%h d_rdata=%h required 0 C0DE0020 C0DE0010",
               i_rvalid, i_rdata, d_rdata);
    end
    next_cycle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #1;
    test_reset();
    test_inst_stream();
    test_priority();
    test_starvation();
    test_write();
    test_reset_inflight();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
